// File: rtl/motor_pkg.sv
// Shared types and helpers for the motor command path: FSM states,
// PWM period derivation and saturating magnitude.
package motor_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    function automatic int period_of(input int speed_w);
        return (1 << (speed_w - 1)) - 1;
    endfunction

    // The most-negative command has no positive twin, so it clamps to lim.
    function automatic int sat_abs(input int v, input int lim);
        int m;
        m = (v < 0) ? -v : v;
        return (m > lim) ? lim : m;
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Prescaled PWM: duty_in loads at the period boundary (bypass on that cycle), restart opens a
// fresh period at once. pwm is registered (one cycle after its inputs); no backpressure.
module pwm_gen #(
    parameter int PRESCALE = 16,
    parameter int PERIOD   = 127,
    parameter int DUTY_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              restart,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              run,
    output logic              pwm,
    output logic              boundary
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]   presc, presc_n;
    logic [DUTY_W-1:0] cnt, cnt_n;
    logic [DUTY_W-1:0] mag_active, active_n;
    logic              tick;

    always_comb begin
        tick     = (presc == PS_W'(PRESCALE - 1));
        boundary = tick && (cnt == DUTY_W'(PERIOD - 1));
        presc_n  = tick ? '0 : presc + 1'b1;
        cnt_n    = cnt;
        if (boundary) begin
            cnt_n = '0;
        end else if (tick) begin
            cnt_n = cnt + 1'b1;
        end
        active_n = boundary ? duty_in : mag_active;
        if (restart) begin
            presc_n  = '0;
            cnt_n    = '0;
            active_n = duty_in;
        end
    end

    // Compare against next-cycle values so the registered pwm lines up with cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            cnt        <= '0;
            mag_active <= '0;
            pwm        <= 1'b0;
        end else begin
            presc      <= presc_n;
            cnt        <= cnt_n;
            mag_active <= active_n;
            pwm        <= run && (cnt_n < active_n);
        end
    end

endmodule

// File: rtl/motor_cmd.sv
// Signed speed command to pwm/dir/en with a timed coast on every reversal.
// Outputs change one cycle after command acceptance; cmd_ready drops for the whole coast.
module motor_cmd
    import motor_pkg::*;
#(
    parameter int SPEED_W     = 8,
    parameter int PRESCALE    = 16,
    parameter int DEAD_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [SPEED_W-1:0] cmd_speed,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic                      pwm,
    output logic                      dir,
    output logic                      en,
    output logic                      reversing
);
    localparam int PERIOD = period_of(SPEED_W);
    localparam int MAG_W  = SPEED_W - 1;
    localparam int DC_W   = $clog2(DEAD_CYCLES + 1);

    state_t             state, state_n;
    logic [MAG_W-1:0]   mag_pending, pending_n, cmd_mag;
    logic               dir_latched, latched_n;
    logic [DC_W-1:0]    dead_cnt;
    logic               accept, cmd_zero, cmd_dir, restart;
    logic               unused_boundary;

    assign cmd_ready = (state != DEAD);
    assign reversing = (state == DEAD);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_zero  = (cmd_speed == '0);
    assign cmd_dir   = ~cmd_speed[SPEED_W-1];
    assign cmd_mag   = MAG_W'(sat_abs(int'(cmd_speed), PERIOD));

    // dir doubles as the remembered sign of the most recent RUN.
    always_comb begin
        state_n   = state;
        pending_n = mag_pending;
        latched_n = dir_latched;
        restart   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept && !cmd_zero) begin
                    pending_n = cmd_mag;
                    latched_n = cmd_dir;
                    if (cmd_dir == dir) begin
                        state_n = RUN;
                        restart = 1'b1;
                    end else begin
                        state_n = DEAD;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (cmd_zero) begin
                        state_n = IDLE;
                    end else begin
                        pending_n = cmd_mag;
                        latched_n = cmd_dir;
                        if (cmd_dir != dir) begin
                            state_n = DEAD;
                        end
                    end
                end
            end
            DEAD: begin
                if (dead_cnt == DC_W'(DEAD_CYCLES - 1)) begin
                    state_n = RUN;
                    restart = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mag_pending <= '0;
            dir_latched <= 1'b1;
            dir         <= 1'b1;
            en          <= 1'b0;
            dead_cnt    <= '0;
        end else begin
            state       <= state_n;
            mag_pending <= pending_n;
            dir_latched <= latched_n;
            en          <= (state_n == RUN);
            dead_cnt    <= (state == DEAD && state_n == DEAD) ? dead_cnt + 1'b1 : '0;
            if (restart) begin
                dir <= latched_n;
            end
        end
    end

    pwm_gen #(
        .PRESCALE (PRESCALE),
        .PERIOD   (PERIOD),
        .DUTY_W   (MAG_W)
    ) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .duty_in  (pending_n),
        .run      (state_n == RUN),
        .pwm      (pwm),
        .boundary (unused_boundary)
    );

endmodule

// File: tb/tb_motor_cmd.sv
// Directed bench for motor_cmd with PRESCALE=2, DEAD_CYCLES=8 (period = 254 clk cycles).
module tb_motor_cmd;
    logic              clk;
    logic              rst;
    logic signed [7:0] cmd_speed;
    logic              cmd_valid;
    logic              cmd_ready, pwm, dir, en, reversing;

    int total = 0;
    int bad   = 0;
    int h;

    motor_cmd #(
        .SPEED_W     (8),
        .PRESCALE    (2),
        .DEAD_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_speed (cmd_speed),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .pwm       (pwm),
        .dir       (dir),
        .en        (en),
        .reversing (reversing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {en, pwm, dir, cmd_ready, reversing}
    function automatic logic [4:0] outs();
        return {en, pwm, dir, cmd_ready, reversing};
    endfunction

    task automatic send(input logic signed [7:0] v);
        cmd_speed = v;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        cmd_speed = '0;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            if (pwm === 1'b1) hi++;
            step();
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_speed = '0;
        step();
        step();
        check("reset_outs", outs(), 5'b00110);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("idle_outs", outs(), 5'b00110);
            step();
        end

        // +64 from IDLE: immediate start, 128 of 254 cycles high
        send(8'sd64);
        check("fwd64_start", outs(), 5'b11110);
        count_high(254, h);
        check("fwd64_duty_p1", h, 128);
        count_high(254, h);
        check("fwd64_duty_p2", h, 128);

        // stop, restart at +64, update to +32 mid-period
        send(8'sd0);
        check("stop_outs", outs(), 5'b00110);
        send(8'sd64);
        check("upd_start", outs(), 5'b11110);
        h = 0;
        for (int i = 0; i < 50; i++) begin
            if (pwm === 1'b1) h++;
            step();
        end
        cmd_speed = 8'sd32;
        cmd_valid = 1'b1;
        if (pwm === 1'b1) h++;
        step();
        cmd_valid = 1'b0;
        cmd_speed = '0;
        for (int i = 0; i < 203; i++) begin
            if (pwm === 1'b1) h++;
            step();
        end
        check("upd_cur_period", h, 128);
        count_high(254, h);
        check("upd_next_period", h, 64);

        // +64 then -100: 8-cycle coast, dir flips only when en returns
        send(8'sd64);
        for (int i = 0; i < 10; i++) begin
            check("run_dir_stable", {en, dir}, 2'b11);
            step();
        end
        send(-8'sd100);
        for (int i = 0; i < 8; i++) begin
            check("dead_outs", outs(), 5'b00101);
            step();
        end
        check("rev_resume", outs(), 5'b11010);
        count_high(254, h);
        check("rev_duty", h, 200);

        // -128 saturates to full duty; 0 stops next cycle
        send(8'sd0);
        check("stop_rev", outs(), 5'b00010);
        send(-8'sd128);
        check("sat_start", outs(), 5'b11010);
        count_high(254, h);
        check("sat_duty", h, 254);
        send(8'sd0);
        check("sat_stop", outs(), 5'b00010);

        // reversal from IDLE aborted by reset on the 4th coast cycle
        send(8'sd50);
        check("abort_dead1", outs(), 5'b00001);
        step();
        step();
        step();
        check("abort_dead4", outs(), 5'b00001);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_reset", outs(), 5'b00110);
        step();
        check("abort_idle", outs(), 5'b00110);
        send(8'sd10);
        check("post_rst_run", outs(), 5'b11110);
        count_high(254, h);
        check("post_rst_duty", h, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
